// File: rtl/tow_pkg.sv
// Shared definitions for the tug-of-war round controller.
// Holds the FSM state encoding, marker end/centre helpers and the position width function.
package tow_pkg;

    localparam int unsigned ST_W = 3;

    localparam logic [ST_W-1:0] ST_CLEAR   = 3'd0;
    localparam logic [ST_W-1:0] ST_RELEASE = 3'd1;
    localparam logic [ST_W-1:0] ST_IDLE    = 3'd2;
    localparam logic [ST_W-1:0] ST_SETTLE  = 3'd3;
    localparam logic [ST_W-1:0] ST_WIN     = 3'd4;

    // Left end of the rope is always marker position 0
    localparam int unsigned LEFT_END = 0;

    // Bits needed to hold a marker position 0..n-1
    function automatic int unsigned pos_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Starting (centre) position of the marker
    function automatic int unsigned center_pos(input int unsigned n);
        return (n - 1) / 2;
    endfunction

    // Right end of the rope
    function automatic int unsigned right_end(input int unsigned n);
        return n - 1;
    endfunction

endpackage

// File: rtl/tow_led_decoder.sv
// Marker position to one-hot LED decode.
// Ports: pos (marker position), leds (one-hot, bit pos lit).
module tow_led_decoder
    import tow_pkg::*;
#(
    parameter int unsigned NUM_LEDS = 9
) (
    input  logic [pos_width(NUM_LEDS)-1:0] pos,
    output logic [NUM_LEDS-1:0]            leds
);

    always_comb begin
        leds = {{(NUM_LEDS-1){1'b0}}, 1'b1} << pos;
    end

endmodule

// File: rtl/tow_round_ctrl.sv
// Tug-of-war round/score controller: sequences each round from the button latch
// (first push, settle window, move marker, clear latch, wait for release) and
// declares a winner when the marker reaches an end LED.
// Ports: clk, rst_n (async active-low); push/tie/right from the latch; new_game pulse;
//        clear to the latch; leds/pos marker; winner_valid/winner_right;
//        score_left/score_right when TOW_SCORE_EN is defined.
// Build option: TOW_SCORE_EN adds saturating per-player game win counters.
module tow_round_ctrl
    import tow_pkg::*;
#(
    parameter int unsigned NUM_LEDS      = 9,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned CLEAR_CYCLES  = 2
`ifdef TOW_SCORE_EN
    ,
    parameter int unsigned SCORE_W       = 4
`endif
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           tie,
    input  logic                           right,
    input  logic                           new_game,
    output logic                           clear,
    output logic [NUM_LEDS-1:0]            leds,
    output logic [pos_width(NUM_LEDS)-1:0] pos,
    output logic                           winner_valid,
    output logic                           winner_right
`ifdef TOW_SCORE_EN
    ,
    output logic [SCORE_W-1:0]             score_left,
    output logic [SCORE_W-1:0]             score_right
`endif
);

    localparam int unsigned PW      = pos_width(NUM_LEDS);
    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > CLEAR_CYCLES) ? SETTLE_CYCLES : CLEAR_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [PW-1:0]    CENTER     = PW'(center_pos(NUM_LEDS));
    localparam logic [PW-1:0]    POS_FIRST  = PW'(LEFT_END);
    localparam logic [PW-1:0]    POS_LAST   = PW'(right_end(NUM_LEDS));
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [ST_W-1:0]  state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             tie_seen, tie_seen_n;
    logic [PW-1:0]    pos_n, moved_pos;
    logic             clear_n, winner_valid_n, winner_right_n;

    // Candidate marker position for the current round; tie includes this cycle's sample
    always_comb begin
        moved_pos = pos;
        if (tie_seen || tie) begin
            moved_pos = pos;
        end else if (right) begin
            moved_pos = (pos == POS_LAST) ? pos : pos + PW'(1);
        end else begin
            moved_pos = (pos == POS_FIRST) ? pos : pos - PW'(1);
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        tie_seen_n     = tie_seen;
        pos_n          = pos;
        winner_valid_n = winner_valid;
        winner_right_n = winner_right;

        case (state)
            ST_CLEAR: begin
                if (cnt == CLEAR_LAST) begin
                    state_n = ST_RELEASE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                // A button still held from the last round must not score twice
                if (!push) begin
                    state_n = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (push) begin
                    state_n    = ST_SETTLE;
                    cnt_n      = '0;
                    tie_seen_n = tie;
                end
            end
            ST_SETTLE: begin
                if (!push) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else if (cnt == SETTLE_LAST) begin
                    pos_n = moved_pos;
                    cnt_n = '0;
                    if ((moved_pos == POS_LAST) || (moved_pos == POS_FIRST)) begin
                        state_n        = ST_WIN;
                        winner_valid_n = 1'b1;
                        winner_right_n = (moved_pos == POS_LAST);
                    end else begin
                        state_n = ST_CLEAR;
                    end
                end else begin
                    cnt_n      = cnt + CNT_W'(1);
                    tie_seen_n = tie_seen | tie;
                end
            end
            ST_WIN: begin
                state_n = ST_WIN;
            end
            default: begin
                state_n = ST_CLEAR;
                cnt_n   = '0;
            end
        endcase

        // Restart wins over any move scored in the same cycle
        if (new_game) begin
            state_n        = ST_CLEAR;
            cnt_n          = '0;
            tie_seen_n     = 1'b0;
            pos_n          = CENTER;
            winner_valid_n = 1'b0;
            winner_right_n = 1'b0;
        end

        clear_n = (state_n == ST_CLEAR) || (state_n == ST_WIN);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_CLEAR;
            cnt          <= '0;
            tie_seen     <= 1'b0;
            pos          <= CENTER;
            clear        <= 1'b1;
            winner_valid <= 1'b0;
            winner_right <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            tie_seen     <= tie_seen_n;
            pos          <= pos_n;
            clear        <= clear_n;
            winner_valid <= winner_valid_n;
            winner_right <= winner_right_n;
        end
    end

`ifdef TOW_SCORE_EN
    // Game win counters: bump once on entry to WIN, saturate, survive new_game
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_left  <= '0;
            score_right <= '0;
        end else if ((state != ST_WIN) && (state_n == ST_WIN)) begin
            if (winner_right_n) begin
                if (score_right != {SCORE_W{1'b1}}) score_right <= score_right + SCORE_W'(1);
            end else begin
                if (score_left != {SCORE_W{1'b1}}) score_left <= score_left + SCORE_W'(1);
            end
        end
    end
`endif

    tow_led_decoder #(
        .NUM_LEDS(NUM_LEDS)
    ) u_led_decoder (
        .pos  (pos),
        .leds (leds)
    );

endmodule

// File: tb/tb_tow_round_ctrl.sv
// Self-checking bench for tow_round_ctrl (NUM_LEDS=9, SETTLE_CYCLES=16, CLEAR_CYCLES=2).
// A round-level model tracks marker position, winner and scores.
module tb_tow_round_ctrl;

    localparam int unsigned NL     = 9;
    localparam int unsigned SC     = 16;
    localparam int unsigned CENTER = 4;
    localparam int unsigned PW     = 4;
    localparam int          SMAX   = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          push = 1'b0;
    logic          tie = 1'b0;
    logic          right = 1'b0;
    logic          new_game = 1'b0;
    logic          clear;
    logic [NL-1:0] leds;
    logic [PW-1:0] pos;
    logic          winner_valid;
    logic          winner_right;
`ifdef TOW_SCORE_EN
    logic [3:0]    score_left;
    logic [3:0]    score_right;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Round-level model
    int m_pos = CENTER;
    bit m_won = 1'b0;
    bit m_wr  = 1'b0;
    int m_sl  = 0;
    int m_sr  = 0;

    always #5 clk = ~clk;

    tow_round_ctrl #(
        .NUM_LEDS(NL),
        .SETTLE_CYCLES(SC),
        .CLEAR_CYCLES(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push),
        .tie          (tie),
        .right        (right),
        .new_game     (new_game),
        .clear        (clear),
        .leds         (leds),
        .pos          (pos),
        .winner_valid (winner_valid),
        .winner_right (winner_right)
`ifdef TOW_SCORE_EN
        ,
        .score_left   (score_left),
        .score_right  (score_right)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One scored round: marker moves toward the first pusher unless a tie was seen
    function automatic void model_round(input bit r, input bit t);
        if (!t) m_pos = r ? m_pos + 1 : m_pos - 1;
        if (m_pos == 0 || m_pos == NL - 1) begin
            m_won = 1'b1;
            m_wr  = (m_pos == NL - 1);
            if (m_wr) m_sr = (m_sr < SMAX) ? m_sr + 1 : SMAX;
            else      m_sl = (m_sl < SMAX) ? m_sl + 1 : SMAX;
        end
    endfunction

    task automatic chk_scores();
`ifdef TOW_SCORE_EN
        chk("score_left", 32'(score_left), m_sl);
        chk("score_right", 32'(score_right), m_sr);
`endif
    endtask

    // Full round from IDLE; tie_cyc>0 pulses tie in that settle cycle; hold keeps push after the clear
    task automatic play_round(input bit r, input int tie_cyc, input int hold);
        int old;
        old   = m_pos;
        push  = 1'b1;
        right = r;
        tie   = 1'b0;
        for (int k = 1; k <= SC + 1; k++) begin
            tie = (tie_cyc > 0) && (k == tie_cyc + 1);
            step();
            if (k == SC) chk("pos_before_move", 32'(pos), old);
        end
        tie = 1'b0;
        model_round(r, tie_cyc > 0);
        chk("pos_after_move", 32'(pos), m_pos);
        chk("leds", 32'(leds), 32'(1) << m_pos);
        chk("winner_valid", 32'(winner_valid), 32'(m_won));
        if (m_won) chk("winner_right", 32'(winner_right), 32'(m_wr));
        step();
        chk("clear_hold", 32'(clear), 1);
        step();
        chk("clear_end", 32'(clear), 32'(m_won));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) step();
            chk("held_no_move", 32'(pos), m_pos);
            chk("held_clear", 32'(clear), 32'(m_won));
        end
        push = 1'b0;
        step();
        step();
        chk_scores();
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        m_pos = CENTER;
        m_won = 1'b0;
        m_wr  = 1'b0;
        chk("ng_pos", 32'(pos), CENTER);
        chk("ng_winner_valid", 32'(winner_valid), 0);
        chk("ng_clear", 32'(clear), 1);
        step();
        step();
        chk("ng_clear_done", 32'(clear), 0);
        step();
    endtask

    initial begin
        // Reset values
        step();
        step();
        chk("rst_pos", 32'(pos), CENTER);
        chk("rst_leds", 32'(leds), 32'h10);
        chk("rst_clear", 32'(clear), 1);
        chk("rst_winner_valid", 32'(winner_valid), 0);
        chk("rst_winner_right", 32'(winner_right), 0);
        chk_scores();
        rst_n = 1'b1;
        step();
        chk("post_rst_clear1", 32'(clear), 1);
        step();
        chk("post_rst_clear0", 32'(clear), 0);
        step();

        // Right push moves marker to 5
        play_round(1'b1, 0, 0);

        // Tie in settle cycle 10 keeps the marker at centre
        do_new_game();
        play_round(1'b0, 10, 0);

        // Push held across the clear scores only once
        play_round(1'b1, 0, 20);

        // Push dropped mid-settle: no move, no clear
        push  = 1'b1;
        right = 1'b1;
        for (int i = 0; i < 5; i++) step();
        push = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("drop_pos", 32'(pos), m_pos);
        chk("drop_clear", 32'(clear), 0);

        // Four right wins from centre end the game
        do_new_game();
        for (int i = 0; i < 4; i++) play_round(1'b1, 0, 0);
        chk("win_pos", 32'(pos), NL - 1);
        push  = 1'b1;
        right = 1'b0;
        for (int i = 0; i < 25; i++) step();
        chk("win_frozen_pos", 32'(pos), NL - 1);
        chk("win_frozen_valid", 32'(winner_valid), 1);
        chk("win_frozen_clear", 32'(clear), 1);
        push = 1'b0;
        step();
        do_new_game();
        chk_scores();

        // new_game on the settle exit edge overrides the move
        play_round(1'b1, 0, 0);
        push  = 1'b1;
        right = 1'b1;
        for (int k = 1; k <= SC + 1; k++) begin
            new_game = (k == SC + 1);
            step();
        end
        new_game = 1'b0;
        push     = 1'b0;
        m_pos    = CENTER;
        chk("ng_exit_pos", 32'(pos), CENTER);
        chk("ng_exit_clear", 32'(clear), 1);
        chk("ng_exit_winner", 32'(winner_valid), 0);
        step();
        step();
        step();
        chk("ng_exit_clear_done", 32'(clear), 0);

        // Asynchronous reset in the middle of settle
        play_round(1'b0, 0, 0);
        push  = 1'b1;
        right = 1'b1;
        for (int i = 0; i < 8; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        m_pos = CENTER;
        m_won = 1'b0;
        m_sl  = 0;
        m_sr  = 0;
        chk("async_rst_pos", 32'(pos), CENTER);
        chk("async_rst_leds", 32'(leds), 32'h10);
        chk("async_rst_clear", 32'(clear), 1);
        chk_scores();
        push = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        step();

        // Randomised rounds against the model
        for (int n = 0; n < 60; n++) begin
            bit r;
            int tc;
            r  = 1'($urandom_range(0, 1));
            tc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : 0;
            play_round(r, tc, ($urandom_range(0, 3) == 0) ? 3 : 0);
            if (m_won) do_new_game();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
